// File: rtl/i2c_read_word_pkg.sv
// Shared encodings and framing constants for the I2C read master.
package i2c_pkg;

    typedef enum logic [7:0] {
        IDLE   = 8'd0,
        START  = 8'd1,
        LOW    = 8'd2,
        DRIVE  = 8'd3,
        HIGH   = 8'd4,
        SAMPLE = 8'd5,
        STOP0  = 8'd6,
        STOP1  = 8'd7,
        STOP2  = 8'd8,
        DONE   = 8'd9
    } state_e;

    localparam int unsigned BITS_PER_FRAME = 9;
    localparam int unsigned TICKS_PER_BIT  = 4;
    localparam logic        READ_BIT       = 1'b1;

    // Edge (relative to the IDLE edge that samples GO) at which END_OK rises.
    function automatic int unsigned done_edge(input int unsigned nbytes);
        return 5 + BITS_PER_FRAME * TICKS_PER_BIT * (1 + nbytes);
    endfunction

endpackage

// File: rtl/i2c_read_word_if.sv
// Request/bus bundle between the read master and its environment.
interface i2c_read_word_if;

    logic        GO;
    logic [7:0]  SLAVE_ADDRESS;
    logic        SDAI;
    logic        SDAO;
    logic        SCLO;
    logic        END_OK;
    logic        ACK_OK;
    logic [15:0] DATA;
    logic [7:0]  ST;

    modport master (
        input  GO, SLAVE_ADDRESS, SDAI,
        output SDAO, SCLO, END_OK, ACK_OK, DATA, ST
    );

    modport slave (
        output GO, SLAVE_ADDRESS, SDAI,
        input  SDAO, SCLO, END_OK, ACK_OK, DATA, ST
    );

endinterface

// File: rtl/i2c_read_word.sv
// I2C read master: START, address with R/W=1, NBYTES data bytes (ACK all but last), STOP.
// One bus phase per PT_CK rising edge; all bus outputs are registered.
module i2c_read_word
    import i2c_pkg::*;
#(
    parameter int unsigned NBYTES = 2
) (
    input logic               PT_CK,
    input logic               RESET_N,
    i2c_read_word_if.master   bus
);

    localparam logic [3:0] LastBit = 4'(BITS_PER_FRAME - 1);

    state_e      state_q;
    logic        sdao_q;
    logic        sclo_q;
    logic        end_ok_q;
    logic        ack_ok_q;
    logic [15:0] data_q;
    logic [3:0]  bit_cnt_q;
    logic [1:0]  byte_cnt_q;
    logic [7:0]  tx_sr_q;
    logic [15:0] rx_acc_q;
    logic        last_byte;

    // byte_cnt_q == 0 is the address frame; 1..NBYTES are data frames.
    assign last_byte = (byte_cnt_q == 2'(NBYTES));

    always_ff @(posedge PT_CK) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            sdao_q     <= 1'b1;
            sclo_q     <= 1'b1;
            end_ok_q   <= 1'b1;
            ack_ok_q   <= 1'b0;
            data_q     <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            tx_sr_q    <= '0;
            rx_acc_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    sdao_q <= 1'b1;
                    sclo_q <= 1'b1;
                    if (bus.GO) begin
                        end_ok_q   <= 1'b0;
                        tx_sr_q    <= {bus.SLAVE_ADDRESS[7:1], READ_BIT};
                        rx_acc_q   <= '0;
                        bit_cnt_q  <= '0;
                        byte_cnt_q <= '0;
                        state_q    <= START;
                    end
                end
                START: begin
                    sdao_q  <= 1'b0;
                    sclo_q  <= 1'b1;
                    state_q <= LOW;
                end
                LOW: begin
                    sclo_q  <= 1'b0;
                    state_q <= DRIVE;
                end
                DRIVE: begin
                    if (bit_cnt_q == LastBit) begin
                        // Address frame releases for the slave ACK; data frames ACK all but last.
                        sdao_q <= (byte_cnt_q == 2'd0) || last_byte;
                    end else if (byte_cnt_q == 2'd0) begin
                        sdao_q  <= tx_sr_q[7];
                        tx_sr_q <= {tx_sr_q[6:0], 1'b0};
                    end else begin
                        sdao_q <= 1'b1;
                    end
                    state_q <= HIGH;
                end
                HIGH: begin
                    sclo_q  <= 1'b1;
                    state_q <= SAMPLE;
                end
                SAMPLE: begin
                    sclo_q <= 1'b1;
                    if (bit_cnt_q != LastBit) begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (byte_cnt_q != 2'd0) begin
                            rx_acc_q <= {rx_acc_q[14:0], bus.SDAI};
                        end
                        state_q <= LOW;
                    end else begin
                        bit_cnt_q <= '0;
                        if (byte_cnt_q == 2'd0) begin
                            if (!bus.SDAI) begin
                                ack_ok_q   <= 1'b1;
                                byte_cnt_q <= 2'd1;
                                state_q    <= LOW;
                            end else begin
                                ack_ok_q <= 1'b0;
                                state_q  <= STOP0;
                            end
                        end else if (last_byte) begin
                            state_q <= STOP0;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            state_q    <= LOW;
                        end
                    end
                end
                STOP0: begin
                    sdao_q  <= 1'b0;
                    sclo_q  <= 1'b0;
                    state_q <= STOP1;
                end
                STOP1: begin
                    sdao_q  <= 1'b0;
                    sclo_q  <= 1'b1;
                    state_q <= STOP2;
                end
                STOP2: begin
                    sdao_q  <= 1'b1;
                    sclo_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    // First DONE edge only: publish the word if the address was ACKed.
                    if (!end_ok_q) begin
                        end_ok_q <= 1'b1;
                        if (ack_ok_q) begin
                            data_q <= rx_acc_q;
                        end
                    end
                    if (!bus.GO) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.SDAO   = sdao_q;
    assign bus.SCLO   = sclo_q;
    assign bus.END_OK = end_ok_q;
    assign bus.ACK_OK = ack_ok_q;
    assign bus.DATA   = data_q;
    assign bus.ST     = state_q;

endmodule

// File: tb/tb_i2c_read_word.sv
// Bench for i2c_read_word: NBYTES=2 and NBYTES=1 instances driven by a bus-level slave model.
module tb_i2c_read_word;
    import i2c_pkg::*;

    logic PT_CK;
    logic RESET_N;

    i2c_read_word_if bus_a ();
    i2c_read_word_if bus_b ();

    i2c_read_word #(.NBYTES(2)) dut_a (.PT_CK(PT_CK), .RESET_N(RESET_N), .bus(bus_a));
    i2c_read_word #(.NBYTES(1)) dut_b (.PT_CK(PT_CK), .RESET_N(RESET_N), .bus(bus_b));

    logic        go_v     [2];
    logic [7:0]  addr_v   [2];
    logic        sdai_v   [2];
    logic        sdao_w   [2];
    logic        sclo_w   [2];
    logic        end_ok_w [2];
    logic        ack_ok_w [2];
    logic [15:0] data_w   [2];
    logic [7:0]  st_w     [2];

    assign bus_a.GO = go_v[0];
    assign bus_b.GO = go_v[1];
    assign bus_a.SLAVE_ADDRESS = addr_v[0];
    assign bus_b.SLAVE_ADDRESS = addr_v[1];
    assign bus_a.SDAI = sdai_v[0];
    assign bus_b.SDAI = sdai_v[1];
    assign sdao_w[0] = bus_a.SDAO;
    assign sdao_w[1] = bus_b.SDAO;
    assign sclo_w[0] = bus_a.SCLO;
    assign sclo_w[1] = bus_b.SCLO;
    assign end_ok_w[0] = bus_a.END_OK;
    assign end_ok_w[1] = bus_b.END_OK;
    assign ack_ok_w[0] = bus_a.ACK_OK;
    assign ack_ok_w[1] = bus_b.ACK_OK;
    assign data_w[0] = bus_a.DATA;
    assign data_w[1] = bus_b.DATA;
    assign st_w[0] = bus_a.ST;
    assign st_w[1] = bus_b.ST;

    initial PT_CK = 1'b0;
    always #5 PT_CK = ~PT_CK;

    // Slave configuration (written by the test) and observations (written by the slave model).
    bit          s_ack  [2];
    logic [7:0]  s_d0   [2];
    logic [7:0]  s_d1   [2];
    int          starts [2];
    int          stops  [2];
    int          rises  [2];
    bit          in_txn [2];
    logic        p_scl  [2];
    logic        p_sda  [2];
    logic [7:0]  addr_seen [2];
    int          mack_cnt  [2];
    logic [3:0]  mack_bits [2];
    logic [7:0]  hist      [2];

    // Bus-level slave: reacts to SCL rising, samples wire phases 1 time unit after each edge.
    always @(posedge PT_CK) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            logic scl;
            logic sda;
            int   frame;
            int   pos;
            scl = sclo_w[i];
            sda = sdao_w[i];
            hist[i] = {hist[i][5:0], sda, scl};
            if (!RESET_N) begin
                in_txn[i] = 1'b0;
                rises[i]  = 0;
                sdai_v[i] = 1'b1;
            end else if (p_scl[i] && scl && p_sda[i] && !sda) begin
                starts[i]++;
                in_txn[i]    = 1'b1;
                rises[i]     = 0;
                addr_seen[i] = '0;
                mack_cnt[i]  = 0;
                mack_bits[i] = '0;
            end else if (p_scl[i] && scl && !p_sda[i] && sda) begin
                stops[i]++;
                in_txn[i] = 1'b0;
                sdai_v[i] = 1'b1;
            end else if (!p_scl[i] && scl && in_txn[i]) begin
                frame = rises[i] / 9;
                pos   = rises[i] % 9;
                rises[i]++;
                if (frame == 0) begin
                    if (pos < 8) begin
                        addr_seen[i] = {addr_seen[i][6:0], sda};
                        sdai_v[i]    = 1'b1;
                    end else begin
                        sdai_v[i] = s_ack[i] ? 1'b0 : 1'b1;
                    end
                end else if (pos < 8) begin
                    sdai_v[i] = (frame == 1) ? s_d0[i][7 - pos] : s_d1[i][7 - pos];
                end else begin
                    mack_bits[i] = {mack_bits[i][2:0], sda};
                    mack_cnt[i]++;
                    sdai_v[i] = 1'b1;
                end
            end
            p_scl[i] = scl;
            p_sda[i] = sda;
        end
    end

    int total;
    int bad;
    logic [15:0] model_data [2];

    task automatic tick();
        @(posedge PT_CK);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int nb_of(input int idx);
        return (idx == 0) ? 2 : 1;
    endfunction

    // Reference: expected master ACK/NACK bits, one per data frame, oldest in the high bit.
    function automatic logic [3:0] exp_macks(input int nb, input bit ack);
        logic [3:0] m;
        m = '0;
        if (ack) begin
            for (int k = 1; k <= nb; k++) m = {m[2:0], (k == nb)};
        end
        return m;
    endfunction

    task automatic run_txn(input int idx, input logic [7:0] addr, input bit ack,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input logic [15:0] exp_data, input int exp_end,
                           input logic [7:0] exp_wire, input bit wiggle, input bit keep_go);
        int n;
        int st0;
        int sp0;
        int nb;
        nb = nb_of(idx);
        s_ack[idx] = ack;
        s_d0[idx]  = d0;
        s_d1[idx]  = d1;
        st0 = starts[idx];
        sp0 = stops[idx];
        addr_v[idx] = addr;
        go_v[idx]   = 1'b1;
        tick();
        chk("end_ok_busy", 32'(end_ok_w[idx]), 32'd0);
        n = 0;
        while (end_ok_w[idx] !== 1'b1 && n < 400) begin
            tick();
            n++;
            if (wiggle && n == 10) go_v[idx] = 1'b0;
            if (wiggle && n == 30) go_v[idx] = 1'b1;
        end
        chk("end_edge", 32'(n), 32'(exp_end));
        chk("ack_ok", 32'(ack_ok_w[idx]), 32'(ack));
        chk("data", 32'(data_w[idx]), 32'(exp_data));
        chk("addr_wire", 32'(addr_seen[idx]), 32'(exp_wire));
        chk("mack_cnt", 32'(mack_cnt[idx]), ack ? 32'(nb) : 32'd0);
        chk("mack_bits", 32'(mack_bits[idx]), 32'(exp_macks(nb, ack)));
        chk("stop_seq", 32'(hist[idx]), 32'b00_01_11_11);
        chk("stop_count", 32'(stops[idx] - sp0), 32'd1);
        chk("start_count", 32'(starts[idx] - st0), 32'd1);
        model_data[idx] = exp_data;
        if (!keep_go) begin
            go_v[idx] = 1'b0;
            tick();
            chk("st_idle", 32'(st_w[idx]), 32'(IDLE));
        end
    endtask

    typedef struct {
        int          idx;
        logic [7:0]  addr;
        bit          ack;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [15:0] exp_data;
        int          exp_end;
        logic [7:0]  exp_wire;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int idx;
        int nb;
        int st0;
        int sp0;
        logic [7:0]  addr;
        bit          ack;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [15:0] ed;

        total = 0;
        bad   = 0;
        for (int i = 0; i < 2; i++) begin
            go_v[i]   = 1'b0;
            addr_v[i] = '0;
            s_ack[i]  = 1'b1;
            s_d0[i]   = '0;
            s_d1[i]   = '0;
            model_data[i] = '0;
        end

        vecs[0] = '{0, 8'h91, 1'b1, 8'h1A, 8'h5C, 16'h1A5C, 113, 8'h91};
        vecs[1] = '{0, 8'h91, 1'b0, 8'h00, 8'h00, 16'h1A5C, 41,  8'h91};
        vecs[2] = '{1, 8'h3C, 1'b1, 8'hA5, 8'h00, 16'h00A5, 77,  8'h3D};
        vecs[3] = '{0, 8'h90, 1'b1, 8'h33, 8'hCC, 16'h33CC, 113, 8'h91};
        vecs[4] = '{1, 8'h22, 1'b0, 8'hFF, 8'hFF, 16'h00A5, 41,  8'h23};

        RESET_N = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_sdao", 32'(sdao_w[i]), 32'd1);
            chk("rst_sclo", 32'(sclo_w[i]), 32'd1);
            chk("rst_end_ok", 32'(end_ok_w[i]), 32'd1);
            chk("rst_ack_ok", 32'(ack_ok_w[i]), 32'd0);
            chk("rst_data", 32'(data_w[i]), 32'd0);
            chk("rst_st", 32'(st_w[i]), 32'(IDLE));
        end
        RESET_N = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            run_txn(vecs[v].idx, vecs[v].addr, vecs[v].ack, vecs[v].d0, vecs[v].d1,
                    vecs[v].exp_data, vecs[v].exp_end, vecs[v].exp_wire, 1'b0, 1'b0);
        end

        // Randomized transactions against the reference model; GO wiggles mid-flight.
        for (int r = 0; r < 8; r++) begin
            idx  = int'($urandom_range(0, 1));
            nb   = nb_of(idx);
            addr = 8'($urandom);
            ack  = ($urandom_range(0, 3) != 0);
            d0   = 8'($urandom);
            d1   = 8'($urandom);
            if (!ack)        ed = model_data[idx];
            else if (nb == 2) ed = {d0, d1};
            else             ed = {8'h00, d0};
            run_txn(idx, addr, ack, d0, d1, ed, ack ? 5 + 36 * (1 + nb) : 41,
                    {addr[7:1], 1'b1}, 1'($urandom_range(0, 1)), 1'b0);
        end

        // GO held across DONE must not retrigger; a low pulse re-arms.
        run_txn(0, 8'hA0, 1'b1, 8'h12, 8'h34, 16'h1234, 113, 8'hA1, 1'b0, 1'b1);
        st0 = starts[0];
        repeat (150) tick();
        chk("hold_no_restart", 32'(starts[0] - st0), 32'd0);
        chk("hold_st_done", 32'(st_w[0]), 32'(DONE));
        chk("hold_end_ok", 32'(end_ok_w[0]), 32'd1);
        go_v[0] = 1'b0;
        tick();
        chk("release_idle", 32'(st_w[0]), 32'(IDLE));
        run_txn(0, 8'h5A, 1'b1, 8'hBE, 8'hEF, 16'hBEEF, 113, 8'h5B, 1'b0, 1'b0);

        // Reset during data byte 1 abandons the bus without a STOP.
        s_ack[0] = 1'b1;
        s_d0[0]  = 8'h77;
        s_d1[0]  = 8'h88;
        addr_v[0] = 8'h44;
        go_v[0]   = 1'b1;
        tick();
        repeat (50) tick();
        chk("mid_busy", 32'(end_ok_w[0]), 32'd0);
        sp0 = stops[0];
        RESET_N = 1'b0;
        tick();
        chk("mrst_sdao", 32'(sdao_w[0]), 32'd1);
        chk("mrst_sclo", 32'(sclo_w[0]), 32'd1);
        chk("mrst_end_ok", 32'(end_ok_w[0]), 32'd1);
        chk("mrst_ack_ok", 32'(ack_ok_w[0]), 32'd0);
        chk("mrst_data", 32'(data_w[0]), 32'd0);
        chk("mrst_st", 32'(st_w[0]), 32'(IDLE));
        chk("mrst_data_b", 32'(data_w[1]), 32'd0);
        RESET_N = 1'b1;
        go_v[0] = 1'b0;
        tick();
        chk("mrst_no_stop", 32'(stops[0] - sp0), 32'd0);
        model_data[0] = '0;
        model_data[1] = '0;

        run_txn(1, 8'h90, 1'b1, 8'h5E, 8'h00, 16'h005E, 77, 8'h91, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
